// File: rtl/lsu_pkg.sv
// Shared types for the multi-byte load/store unit: FSM state encoding and
// the latched request record.
package lsu_pkg;

  localparam int LSU_ADDR_W    = 16;
  localparam int LSU_MAX_BYTES = 2;
  localparam int LSU_LEN_W     = $clog2(LSU_MAX_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic                         write;
    logic [LSU_LEN_W-1:0]         len;
    logic [LSU_ADDR_W-1:0]        addr;
    logic [8*LSU_MAX_BYTES-1:0]   wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_mb.sv
// Multi-byte load/store unit: splits one request of 1..MAX_BYTES bytes into
// back-to-back single-byte memory accesses and assembles loads little-endian.
// Every output is decoded from registered state, so req_* never reaches mem_*
// combinationally, and the asynchronous reset drops mem_en/mem_we at once.
module lsu_mb
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MAX_BYTES = 2,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [LEN_W-1:0]       req_len,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [8*MAX_BYTES-1:0] req_wdata,
  output logic                   resp_valid,
  output logic                   resp_err,
  output logic [8*MAX_BYTES-1:0] resp_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata
);

  localparam int CNT_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int DW    = 8 * MAX_BYTES;

  lsu_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  // Load capture runs one cycle behind the address: cap_vld/cap_idx remember
  // which buffer byte the data now on mem_rdata belongs to.
  logic              cap_vld_q, cap_vld_d;
  logic [CNT_W-1:0]  cap_idx_q, cap_idx_d;
  logic [DW-1:0]     rbuf_q, rbuf_d;

  logic              len_ok;
  logic [LEN_W-1:0]  cnt_plus1;
  logic              last_byte;

  assign len_ok    = (req_len != '0) && (req_len <= LEN_W'(MAX_BYTES));
  assign cnt_plus1 = LEN_W'(cnt_q) + LEN_W'(1);
  assign last_byte = (cnt_plus1 == len_q);

  // Next-state, request latching, byte counter and read-buffer capture.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    len_d     = len_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    cap_vld_d = 1'b0;
    cap_idx_d = cnt_q;
    rbuf_d    = rbuf_q;

    if (cap_vld_q) begin
      rbuf_d[cap_idx_q*8 +: 8] = mem_rdata;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          len_d   = req_len;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          rbuf_d  = '0;
          err_d   = !len_ok;
          state_d = len_ok ? XFER : RESP;
        end
      end
      XFER: begin
        cap_vld_d = !write_q;
        if (last_byte) begin
          state_d = write_q ? RESP : DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      len_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      rbuf_q    <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      rbuf_q    <= rbuf_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = (state_q == RESP) ? rbuf_q : '0;
    mem_en     = (state_q == XFER);
    mem_we     = (state_q == XFER) && write_q;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == XFER) begin
      mem_addr  = addr_q + ADDR_W'(cnt_q);
      mem_wdata = wdata_q[cnt_q*8 +: 8];
    end
  end

endmodule

// File: doc/lsu_mb.md
# lsu_mb

Parametrised multi-byte load/store unit between the CPU backend and the byte-wide system memory. It accepts one load or store request of 1..MAX_BYTES bytes and splits it into a pipelined sequence of single-byte memory accesses at consecutive addresses. Loads are assembled little-endian into one response word. Memory data travels on separate read and write buses; there are no tri-state ports.

## Interface
Parameters:
- ADDR_W, 16, memory address width in bits.
- MAX_BYTES, 2, largest transfer in bytes; must be 1..8.
- LEN_W, $clog2(MAX_BYTES+1), width of the length field (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_len  in  LEN_W  number of bytes N.
- req_addr  in  ADDR_W  address of byte 0.
- req_wdata  in  8*MAX_BYTES  store data; byte i = bits [8i+7:8i].
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; length was illegal.
- resp_rdata  out  8*MAX_BYTES  load data; valid with resp_valid.
- mem_addr  out  ADDR_W  byte address.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write strobe; high only together with mem_en.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; returned the cycle after its address.

## Operation
- States: IDLE, XFER, DRAIN, RESP.
- IDLE:
  - On req_valid && req_ready, latch write, len, addr and wdata; clear the byte counter and the read buffer.
  - Legal N (1..MAX_BYTES): go to XFER.
  - N = 0 or N > MAX_BYTES: go straight to RESP with resp_err=1; no memory access.
- XFER (N cycles, counter i = 0..N-1):
  - Drive mem_en=1, mem_addr=(addr+i) mod 2^ADDR_W, mem_we=write, mem_wdata=wdata byte i.
  - Wrap-around past 2^ADDR_W-1 to 0 is legal.
  - After i=N-1: stores go to RESP, loads go to DRAIN.
- DRAIN (loads only, 1 cycle): mem_en=0; capture the last byte.
- Load capture: mem_rdata is sampled in the cycle after each address. It is written to buffer byte k, where k is the counter value one cycle earlier. Buffer bytes N..MAX_BYTES-1 stay 0.
- RESP (1 cycle):
  - resp_valid=1; resp_rdata = buffer for loads, 0 for stores and errors.
  - Then return to IDLE.
- req_ready=0 in XFER, DRAIN and RESP. A request held across that time is accepted in the first IDLE cycle.

## Timing
- T = acceptance cycle (the rising edge at its end latches the request).
- Cycles T+1..T+N: the N memory accesses, back-to-back, one byte per cycle.
- Loads: byte i is present on mem_rdata in cycle T+2+i; DRAIN is T+N+1; resp_valid is in T+N+2.
- Stores: resp_valid is in T+N+1.
- Errors: resp_valid is in T+1.
- Minimum gap between accepted requests: load N+3 cycles, store N+2 cycles, error 2 cycles.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-transfer:
  - Aborts at once; mem_en and mem_we fall asynchronously.
  - No response is ever issued for the aborted request.
  - Memory writes already strobed are not undone.
- All outputs are registered or decoded from registered state only; no combinational path from req_* to mem_*.

## Structure
- Shared package lsu_pkg holds:
  - The state enum lsu_state_t {IDLE, XFER, DRAIN, RESP}.
  - A request struct lsu_req_t (write, len, addr, wdata), parametrised by the package constants LSU_ADDR_W and LSU_MAX_BYTES.
- Single module lsu_mb; no sub-module.
- Byte counter width: $clog2(MAX_BYTES) bits, minimum 1.

## Test plan
- Load N=2, addr 0x0010, mem[0x10]=0xAB, mem[0x11]=0xCD -> addresses 0x10 and 0x11 in T+1 and T+2; resp_valid in T+4; resp_rdata=0xCDAB; resp_err=0.
- Store N=2, addr 0x0020, wdata 0x1234 -> mem_we writes 0x34@0x20 then 0x12@0x21; resp_valid in T+3; memory reads back 0x1234.
- Wrap: load N=2 at 0xFFFF with mem[0xFFFF]=0x11, mem[0x0000]=0x22 -> mem_addr 0xFFFF then 0x0000; resp_rdata=0x2211.
- Illegal length: N=0, then N=3 -> each gives resp_valid in T+1 with resp_err=1 and resp_rdata=0; mem_en never asserts.
- Back-to-back: req_valid held for two stores -> second accepted exactly in the IDLE cycle after the first RESP; req_ready=0 throughout the first transfer.
- Reset: rst_n low in T+2 of an N=2 load -> mem_en drops the same cycle; no resp_valid; next load after release completes normally.
